// File: rtl/ant_pkg.sv
// Shared fetch-side constants and the FIFO entry type.
// Imported by the fetch FIFO and the instruction_fetch top.
package ant_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Flush empties it in one cycle; the head is read straight from storage.
module fetch_fifo
    import ant_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads the combinational imem and
// queues {pc, instr} for decode; redirects flush the queue.
module instruction_fetch #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = ant_pkg::RESET_PC_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    import ant_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   w_count;
    logic            w_pop;
    logic            w_push;
    logic            w_unused;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_head;

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid & out_ready;
    // A full queue may still accept a word when the head leaves this cycle
    assign w_push    = fetch_en & ~redirect_valid &
                       ((w_count < CW'(DEPTH)) | w_pop);

    assign w_wdata.pc    = r_pc;
    assign w_wdata.instr = imem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(INSTR_BYTES);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr = r_pc;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign w_unused  = ^redirect_pc[1:0];

endmodule
